ifetch_line_buffer: RTL and testbench

Instruction-side memory responder serving the Fetch stage. It accepts Fetch's combinational instruction address and returns instruction data plus a valid flag. It keeps one cache line of LINE_WORDS words in a local line buffer with per-word valid bits, and refills that line from the backing memory through an in-order request/response read channel. It sits between Fetch and the instruction memory or bus, and is the responder end of the fetch address/data interface.

---
 rtl/ifetch_line_buffer_pkg.sv | 14 +
 rtl/ifetch_line_storage.sv | 51 +++++
 rtl/ifetch_line_buffer.sv | 127 ++++++++++++
 tb/tb_ifetch_line_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_line_buffer_pkg.sv
// rtl/ifetch_line_buffer_pkg.sv - shared types and constants for the instruction line buffer
package ifetch_line_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  localparam int unsigned LINE_WORDS_DEFAULT   = 4;
  localparam logic [32:0] MEMORY_BYTES_DEFAULT = 33'h0_0001_0000;

endpackage

// File: rtl/ifetch_line_storage.sv
// rtl/ifetch_line_storage.sv - one instruction line: word array, per-word valid bits, tag, hit lookup
module ifetch_line_storage #(
  parameter  int unsigned LINE_WORDS = 4,
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS),
  localparam int unsigned TAG_W      = 30 - IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_tag_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             hit_o,
  output logic [31:0]      rd_data_o,
  output logic [TAG_W-1:0] line_tag_o
);

  logic [31:0]           words_q [LINE_WORDS];
  logic [LINE_WORDS-1:0] word_valid_q, word_valid_d;
  logic [TAG_W-1:0]      line_tag_q;

  // Clear wins over a same-cycle write so a final word landing with an invalidate leaves the line empty.
  always_comb begin
    word_valid_d = word_valid_q;
    if (wr_en_i) word_valid_d[wr_idx_i] = 1'b1;
    if (clear_i) word_valid_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_valid_q <= '0;
      line_tag_q   <= '0;
    end else begin
      word_valid_q <= word_valid_d;
      if (load_tag_i) line_tag_q <= tag_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) words_q[wr_idx_i] <= wr_data_i;
  end

  assign hit_o      = (line_tag_q == rd_tag_i) && word_valid_q[rd_idx_i];
  assign rd_data_o  = words_q[rd_idx_i];
  assign line_tag_o = line_tag_q;

endmodule

// File: rtl/ifetch_line_buffer.sv
// rtl/ifetch_line_buffer.sv - fetch-side responder: single-line buffer refilled over an in-order read channel
module ifetch_line_buffer
  import ifetch_line_buffer_pkg::*;
#(
  parameter int unsigned LINE_WORDS   = LINE_WORDS_DEFAULT,
  parameter logic [32:0] MEMORY_BYTES = MEMORY_BYTES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instruction_address_i,
  output logic        instruction_data_valid_o,
  output logic [31:0] instruction_data_o,
  input  logic        invalidate_i,
  output logic        mem_read_valid_o,
  output logic [31:0] mem_read_address_o,
  input  logic        mem_read_ready_i,
  input  logic        mem_response_valid_i,
  input  logic [31:0] mem_response_data_i
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] WORDS     = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  fill_state_e      state_q, state_d;
  logic [CNT_W-1:0] req_count_q, req_count_d;
  logic [CNT_W-1:0] resp_count_q, resp_count_d;
  logic             pending_inval_q, pending_inval_d;
  logic             clear, load_tag, wr_en, hit, in_range, req_open;
  logic [31:0]      rd_data;
  logic [TAG_W-1:0] addr_tag, line_tag;
  logic [IDX_W-1:0] addr_idx;

  assign addr_idx = instruction_address_i[IDX_W+1:2];
  assign addr_tag = instruction_address_i[31:IDX_W+2];
  assign in_range = {1'b0, instruction_address_i} < MEMORY_BYTES;

  ifetch_line_storage #(.LINE_WORDS(LINE_WORDS)) u_storage (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear),
    .load_tag_i (load_tag),
    .tag_i      (addr_tag),
    .wr_en_i    (wr_en),
    .wr_idx_i   (resp_count_q[IDX_W-1:0]),
    .wr_data_i  (mem_response_data_i),
    .rd_tag_i   (addr_tag),
    .rd_idx_i   (addr_idx),
    .hit_o      (hit),
    .rd_data_o  (rd_data),
    .line_tag_o (line_tag)
  );

  assign req_open = (state_q == FILL) && (req_count_q < WORDS);

  always_comb begin
    state_d         = state_q;
    req_count_d     = req_count_q;
    resp_count_d    = resp_count_q;
    pending_inval_d = pending_inval_q;
    clear           = 1'b0;
    load_tag        = 1'b0;
    wr_en           = 1'b0;
    case (state_q)
      IDLE: begin
        if (invalidate_i) clear = 1'b1;
        if (in_range && !hit) begin
          load_tag     = 1'b1;
          clear        = 1'b1;
          req_count_d  = '0;
          resp_count_d = '0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (req_open && mem_read_ready_i) req_count_d = req_count_q + ONE;
        if (invalidate_i) pending_inval_d = 1'b1;
        // The fill always drains; a deferred invalidate takes effect with the last word.
        if (mem_response_valid_i) begin
          wr_en        = 1'b1;
          resp_count_d = resp_count_q + ONE;
          if (resp_count_q == LAST_WORD) begin
            state_d = IDLE;
            if (pending_inval_q || invalidate_i) begin
              clear           = 1'b1;
              pending_inval_d = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      req_count_q     <= '0;
      resp_count_q    <= '0;
      pending_inval_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_count_q     <= req_count_d;
      resp_count_q    <= resp_count_d;
      pending_inval_q <= pending_inval_d;
    end
  end

  assign mem_read_valid_o   = req_open;
  assign mem_read_address_o = req_open ? ({line_tag, {(IDX_W+2){1'b0}}} + (32'(req_count_q) << 2)) : 32'h0;

  always_comb begin
    instruction_data_valid_o = 1'b0;
    instruction_data_o       = 32'h0;
    if (!in_range) begin
      instruction_data_valid_o = 1'b1;
      instruction_data_o       = NOP_INSTRUCTION;
    end else if (hit && !pending_inval_q) begin
      instruction_data_valid_o = 1'b1;
      instruction_data_o       = rd_data;
    end
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// tb/tb_ifetch_line_buffer.sv - directed and randomized checks of ifetch_line_buffer against a line/memory model
module tb_ifetch_line_buffer;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] MEM_BYTES = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        dvalid;
  logic [31:0] data;
  logic        inval;
  logic        rvalid;
  logic [31:0] raddr;
  logic        rready;
  logic        respv;
  logic [31:0] respd;

  always #5 clk = ~clk;

  ifetch_line_buffer #(.LINE_WORDS(4), .MEMORY_BYTES(33'h0_0001_0000)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .instruction_address_i    (addr),
    .instruction_data_valid_o (dvalid),
    .instruction_data_o       (data),
    .invalidate_i             (inval),
    .mem_read_valid_o         (rvalid),
    .mem_read_address_o       (raddr),
    .mem_read_ready_i         (rready),
    .mem_response_valid_i     (respv),
    .mem_response_data_i      (respd)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] exp_req[$];
  bit          rdy_pat[$];
  logic [31:0] mem_img [256];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          handshakes = 0;
  int          lat = 2;
  bit          rdy_rand = 1'b0;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return mem_img[a[9:2]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_req.push_back(base + 32'(4 * k));
  endtask

  // One clock: drive ready/response for the new cycle, then score the request channel.
  task automatic next_cycle();
    resp_t r;
    @(posedge clk);
    cyc++;
    #1;
    inval = 1'b0;
    if (rdy_pat.size() > 0) rready = rdy_pat.pop_front();
    else if (rdy_rand)      rready = 1'($urandom_range(0, 1));
    else                    rready = 1'b1;
    respv = 1'b0;
    respd = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      respv = 1'b1;
      respd = mem_of(r.addr);
    end
    #1;
    if (rvalid) begin
      if (exp_req.size() == 0) chk("spurious_request", 32'(rvalid), 32'd0);
      else begin
        chk("request_address", raddr, exp_req[0]);
        if (rready) begin
          rq.push_back('{exp_req[0], cyc + lat});
          void'(exp_req.pop_front());
          handshakes++;
        end
      end
    end
    if (dvalid && addr < MEM_BYTES) chk("data_matches_memory", data, mem_of(addr));
  endtask

  task automatic run_fill();
    int n = 0;
    while ((exp_req.size() > 0 || rq.size() > 0) && n < 200) begin
      next_cycle();
      n++;
    end
    chk("fill_completes_in_bound", 32'(n < 200), 32'd1);
    exp_req.delete();
    rq.delete();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0, hs0, n;
    logic [31:0] a, ref_base;
    bit          ref_full, exp_hit;

    for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
    rst = 1'b1; addr = 32'h0; inval = 1'b0; rready = 1'b1; respv = 1'b0; respd = 32'h0;

    next_cycle();
    next_cycle();
    chk("reset_req_valid", 32'(rvalid), 32'd0);
    chk("reset_req_address", raddr, 32'h0);
    chk("reset_data_valid", 32'(dvalid), 32'd0);
    chk("reset_data", data, 32'h0);
    set_addr(MEM_BYTES);
    rst = 1'b0;

    // Cold miss at 0x0, latency 2
    next_cycle();
    set_addr(32'h0);
    n0 = cyc;
    chk("s1_miss_not_valid", 32'(dvalid), 32'd0);
    push_line(32'h0);
    for (int d = 1; d <= 7; d++) begin
      next_cycle();
      chk("s1_req_valid_window", 32'(rvalid), 32'(d <= 4));
      chk("s1_word0_valid_at_n4", 32'(dvalid), 32'(d >= 4));
    end
    chk("s1_all_requests_served", 32'(exp_req.size() + rq.size()), 32'd0);
    for (int w = 0; w < 4; w++) begin
      set_addr(32'(4 * w));
      chk("s1_word_hit", 32'(dvalid), 32'd1);
      chk("s1_word_data", data, mem_of(addr));
    end
    next_cycle();
    chk("s1_no_further_requests", 32'(rvalid), 32'd0);

    // Mid-line miss
    set_addr(32'h108);
    chk("s2_miss_not_valid", 32'(dvalid), 32'd0);
    push_line(32'h100);
    for (int d = 1; d <= 7; d++) begin
      next_cycle();
      chk("s2_word2_valid_at_n6", 32'(dvalid), 32'(d >= 6));
    end
    set_addr(32'h100);
    chk("s2_word0_hit", 32'(dvalid), 32'd1);

    // Backpressure
    next_cycle();
    set_addr(32'h200);
    push_line(32'h200);
    hs0 = handshakes;
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    next_cycle();
    for (int s = 0; s < 2; s++) begin
      next_cycle();
      chk("s3_stall_valid", 32'(rvalid), 32'd1);
      chk("s3_stall_address", raddr, 32'h204);
    end
    run_fill();
    chk("s3_request_count", 32'(handshakes - hs0), 32'd4);

    // Redirect mid-fill
    next_cycle();
    set_addr(32'h10);
    push_line(32'h10);
    next_cycle();
    next_cycle();
    set_addr(32'h40);
    chk("s4_redirect_not_valid", 32'(dvalid), 32'd0);
    n = 0;
    while ((exp_req.size() > 0 || rq.size() > 0) && n < 40) begin
      next_cycle();
      chk("s4_no_stale_hit", 32'(dvalid), 32'd0);
      n++;
    end
    next_cycle();
    chk("s4_new_line_miss", 32'(dvalid), 32'd0);
    push_line(32'h40);
    run_fill();
    chk("s4_new_line_hit", 32'(dvalid), 32'd1);
    set_addr(32'h10);
    chk("s4_old_line_evicted", 32'(dvalid), 32'd0);
    set_addr(32'h4C);
    chk("s4_last_word_hit", 32'(dvalid), 32'd1);

    // Invalidate with two responses outstanding
    next_cycle();
    set_addr(32'h300);
    push_line(32'h300);
    for (int d = 1; d <= 4; d++) next_cycle();
    chk("s5_word0_before_invalidate", 32'(dvalid), 32'd1);
    inval = 1'b1;
    for (int d = 5; d <= 7; d++) begin
      next_cycle();
      chk("s5_suppressed_while_pending", 32'(dvalid), 32'd0);
    end
    chk("s5_responses_consumed", 32'(rq.size()), 32'd0);
    push_line(32'h300);
    for (int d = 1; d <= 6; d++) next_cycle();
    chk("s5_hit_before_final", 32'(dvalid), 32'd1);
    inval = 1'b1;
    next_cycle();
    chk("s5_final_with_invalidate_empty", 32'(dvalid), 32'd0);
    push_line(32'h300);
    run_fill();
    chk("s5_refill_hit", 32'(dvalid), 32'd1);

    // Out of range and top in-range boundary
    next_cycle();
    set_addr(MEM_BYTES);
    chk("s6_oor_valid", 32'(dvalid), 32'd1);
    chk("s6_oor_nop", data, NOP);
    chk("s6_oor_no_request", 32'(rvalid), 32'd0);
    next_cycle();
    chk("s6_oor_no_request_later", 32'(rvalid), 32'd0);
    set_addr(32'hFFFF_FFFC);
    chk("s6_top_addr_nop", data, NOP);
    set_addr(MEM_BYTES - 32'd4);
    chk("s6_last_inrange_miss", 32'(dvalid), 32'd0);
    push_line(MEM_BYTES - 32'd16);
    run_fill();
    chk("s6_last_inrange_hit", 32'(dvalid), 32'd1);

    // Reset mid-fill
    next_cycle();
    set_addr(32'h380);
    push_line(32'h380);
    for (int d = 1; d <= 3; d++) next_cycle();
    rst = 1'b1;
    #1;
    chk("s7_async_req_valid", 32'(rvalid), 32'd0);
    chk("s7_async_req_address", raddr, 32'h0);
    chk("s7_async_data_valid", 32'(dvalid), 32'd0);
    exp_req.delete();
    set_addr(MEM_BYTES);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    chk("s7_late_responses_drained", 32'(rq.size()), 32'd0);
    set_addr(32'h0);
    chk("s7_late_resp_word0", 32'(dvalid), 32'd0);
    set_addr(32'h4);
    chk("s7_late_resp_word1", 32'(dvalid), 32'd0);
    push_line(32'h0);
    run_fill();
    chk("s7_refill_hit", 32'(dvalid), 32'd1);

    // Randomized: line model tracks which line is resident and complete
    rdy_rand = 1'b1;
    lat      = $urandom_range(1, 4);
    ref_full = 1'b1;
    ref_base = 32'h0;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: begin
          set_addr(MEM_BYTES + (32'($urandom_range(0, 1023)) << 2));
          chk("rand_oor_nop", data, NOP);
          chk("rand_oor_valid", 32'(dvalid), 32'd1);
          next_cycle();
        end
        1: begin
          set_addr(MEM_BYTES);
          inval = 1'b1;
          ref_full = 1'b0;
          next_cycle();
        end
        default: begin
          a = 32'($urandom_range(0, 47)) << 2;
          set_addr(a);
          exp_hit = ref_full && ((a & ~32'hF) == ref_base);
          chk("rand_hit", 32'(dvalid), 32'(exp_hit));
          if (exp_hit) begin
            chk("rand_hit_data", data, mem_of(a));
            next_cycle();
          end else begin
            push_line(a & ~32'hF);
            run_fill();
            ref_full = 1'b1;
            ref_base = a & ~32'hF;
            chk("rand_fill_hit", 32'(dvalid), 32'd1);
            chk("rand_fill_data", data, mem_of(a));
          end
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
